// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scan driver with per-frame input snapshot, PWM brightness,
// blank mask and decimal points. Define SEG_LZB_EN to add leading-zero blanking.
module seg_scan_mux #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 65536,
    parameter int BRIGHT_W   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int   PW   = $clog2(TICK_DIV);
    localparam int   IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   STEP = TICK_DIV >> BRIGHT_W;
    localparam logic POL  = (ACTIVE_LOW != 0);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [BRIGHT_W-1:0]     sh_bright;

    logic [NUM_DIGITS-1:0]   live_blank;
    logic [4*NUM_DIGITS-1:0] cur_digits;
    logic [NUM_DIGITS-1:0]   cur_dp;
    logic [NUM_DIGITS-1:0]   cur_blank;
    logic [BRIGHT_W-1:0]     cur_bright;
    logic [3:0]              nib;
    logic                    dp_bit;
    logic                    blk;
    logic [PW:0]             thr;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_hi;
    logic [6:0]              seg_hi;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
        endcase
    endfunction

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] lzb;
    logic                  lead;

    // Blank zero digits from the left until the first significant one; digit 0 always shows.
    always_comb begin
        lzb  = '0;
        lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead && digits[4*k +: 4] == 4'h0 && !dp[k]) lzb[k] = 1'b1;
            else                                              lead   = 1'b0;
        end
        live_blank = blank | lzb;
    end
`else
    assign live_blank = blank;
`endif

    assign frame_start = (presc == '0) && (idx == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(TICK_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_bright <= '0;
        end else if (frame_start) begin
            sh_digits <= digits;
            sh_dp     <= dp;
            sh_blank  <= live_blank;
            sh_bright <= brightness;
        end
    end

    // The first slot of a frame decodes the live inputs so it already shows the new frame.
    always_comb begin
        cur_digits = frame_start ? digits     : sh_digits;
        cur_dp     = frame_start ? dp         : sh_dp;
        cur_blank  = frame_start ? live_blank : sh_blank;
        cur_bright = frame_start ? brightness : sh_bright;
        nib    = 4'h0;
        dp_bit = 1'b0;
        blk    = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib    = cur_digits[4*k +: 4];
                dp_bit = cur_dp[k];
                blk    = cur_blank[k];
            end
        end
        thr = (PW+1)'((int'(cur_bright) + 1) * STEP);
        lit = !blk && ({1'b0, presc} < thr);
        an_hi = '0;
        for (int k = 0; k < NUM_DIGITS; k++) an_hi[k] = lit && (idx == IW'(k));
        seg_hi = lit ? hex7(nib) : 7'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an     <= {NUM_DIGITS{POL}};
            seg    <= {7{POL}};
            dp_out <= POL;
        end else begin
            an     <= an_hi ^ {NUM_DIGITS{POL}};
            seg    <= seg_hi ^ {7{POL}};
            dp_out <= (lit & dp_bit) ^ POL;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues hand-computed expectations tagged with
// a cycle number, a negedge monitor pops and compares them.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_start;

    seg_scan_mux #(
        .NUM_DIGITS(4), .TICK_DIV(8), .BRIGHT_W(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .digits(digits), .dp(dp), .blank(blank),
        .brightness(brightness), .seg(seg), .dp_out(dp_out), .an(an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input string name, input logic [3:0] a,
                             input logic [6:0] s, input logic d, input logic f);
        exp_t e;
        e.cyc = c; e.name = name; e.an = a; e.seg = s; e.dp = d; e.fs = f;
        q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (e.cyc < cyc) begin
                miscompares++;
                $display("FAIL %s: check for cycle %0d skipped at cycle %0d", e.name, e.cyc, cyc);
            end else if ({an, seg, dp_out, frame_start} !== {e.an, e.seg, e.dp, e.fs}) begin
                miscompares++;
                $display("FAIL %s @%0d: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         e.name, cyc - base, an, seg, dp_out, frame_start, e.an, e.seg, e.dp, e.fs);
            end
        end
    end

    initial begin
        base       = 0;
        rst        = 1'b0;
        digits     = 16'h1234;
        dp         = 4'b0000;
        blank      = 4'b0000;
        brightness = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        expect_at(cyc, "reset_hold", 4'hF, 7'h7F, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        base = cyc;

        expect_at(base + 0,   "fs_first",  4'hF, 7'h7F, 1'b1, 1'b1);
        expect_at(base + 1,   "s0_first",  4'hE, 7'h4C, 1'b1, 1'b0);
        expect_at(base + 8,   "s0_last",   4'hE, 7'h4C, 1'b1, 1'b0);
        expect_at(base + 9,   "s1_three",  4'hD, 7'h06, 1'b1, 1'b0);
        expect_at(base + 17,  "s2_snap",   4'hB, 7'h12, 1'b1, 1'b0);
        expect_at(base + 25,  "s3_snap",   4'h7, 7'h4F, 1'b1, 1'b0);
        expect_at(base + 32,  "fs_repeat", 4'h7, 7'h4F, 1'b1, 1'b1);
        expect_at(base + 33,  "f1_s0_d",   4'hE, 7'h42, 1'b1, 1'b0);
        expect_at(base + 40,  "f1_full",   4'hE, 7'h42, 1'b1, 1'b0);
        expect_at(base + 41,  "f1_s1_C",   4'hD, 7'h31, 1'b1, 1'b0);
        expect_at(base + 57,  "f1_s3_A",   4'h7, 7'h08, 1'b1, 1'b0);
        expect_at(base + 68,  "b1_on",     4'hE, 7'h42, 1'b1, 1'b0);
        expect_at(base + 69,  "b1_off",    4'hF, 7'h7F, 1'b1, 1'b0);
        expect_at(base + 97,  "b0_on_dp",  4'hE, 7'h42, 1'b0, 1'b0);
        expect_at(base + 98,  "b0_on2",    4'hE, 7'h42, 1'b0, 1'b0);
        expect_at(base + 99,  "b0_off",    4'hF, 7'h7F, 1'b1, 1'b0);
        expect_at(base + 105, "dp_s1",     4'hD, 7'h31, 1'b1, 1'b0);
        expect_at(base + 113, "blank_s2",  4'hF, 7'h7F, 1'b1, 1'b0);
        expect_at(base + 121, "s3_A",      4'h7, 7'h08, 1'b1, 1'b0);
        expect_at(base + 128, "fs_f4",     4'hF, 7'h7F, 1'b1, 1'b1);
        expect_at(base + 129, "lzb_s0",    4'hE, 7'h01, 1'b1, 1'b0);
        expect_at(base + 137, "lzb_s1",    4'hD, 7'h24, 1'b1, 1'b0);
`ifdef SEG_LZB_EN
        expect_at(base + 145, "lzb_s2",    4'hF, 7'h7F, 1'b1, 1'b0);
        expect_at(base + 153, "lzb_s3",    4'hF, 7'h7F, 1'b1, 1'b0);
`else
        expect_at(base + 145, "lzb_s2",    4'hB, 7'h01, 1'b1, 1'b0);
        expect_at(base + 153, "lzb_s3",    4'h7, 7'h01, 1'b1, 1'b0);
`endif
        expect_at(base + 162, "async_rst", 4'hF, 7'h7F, 1'b1, 1'b1);

        wait_to(base + 12);
        digits = 16'hABCD;
        wait_to(base + 34);
        brightness = 2'd1;
        wait_to(base + 70);
        brightness = 2'd0;
        blank      = 4'b0100;
        dp         = 4'b0001;
        wait_to(base + 100);
        digits     = 16'h0050;
        dp         = 4'b0000;
        blank      = 4'b0000;
        brightness = 2'd3;
        wait_to(base + 162);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked, cycle %0d", e.name, e.cyc - base);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
